// File: rtl/reg_readout_serializer.sv
// Captures a parallel register word on START and streams it out bit-serially over valid/ready.
// Optional even-parity trailer bit when PARITY_EN is defined.
module reg_readout_serializer #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] D,
   input  logic             START,
   input  logic             SREADY,
   output logic             SOUT,
   output logic             SVALID,
   output logic             BUSY,
   output logic             DONE
);

   localparam int unsigned     CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_FIN   = 2'd3
`ifdef PARITY_EN
      ,
      S_PAR   = 2'd2
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sout_q, sout_d;
   logic             svalid_q, svalid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept;
`ifdef PARITY_EN
   logic             par_q, par_d;
`endif

   assign accept = svalid_q & SREADY;

   // State and datapath registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         shadow_q <= '0;
         cnt_q    <= '0;
         sout_q   <= 1'b0;
         svalid_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         sout_q   <= sout_d;
         svalid_q <= svalid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   // Next state; the shadow shifts so the outgoing bit always sits at a fixed end
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
`ifdef PARITY_EN
      par_d    = par_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (START) begin
               shadow_d = D;
`ifdef PARITY_EN
               par_d    = ^D;
`endif
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (accept) begin
               cnt_d = cnt_q + CW'(1);
               if (MSB_FIRST) begin
                  shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
               end else begin
                  shadow_d = {1'b0, shadow_q[WIDTH-1:1]};
               end
               if (cnt_q == CNT_LAST) begin
`ifdef PARITY_EN
                  state_d = S_PAR;
`else
                  state_d = S_FIN;
`endif
               end
            end
         end
`ifdef PARITY_EN
         S_PAR: begin
            if (accept) begin
               state_d = S_FIN;
            end
         end
`endif
         S_FIN: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Registered outputs are computed from the upcoming state
   always_comb begin
      sout_d   = 1'b0;
      svalid_d = 1'b0;
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_FIN);
      unique case (state_d)
         S_SHIFT: begin
            svalid_d = 1'b1;
            sout_d   = MSB_FIRST ? shadow_d[WIDTH-1] : shadow_d[0];
         end
`ifdef PARITY_EN
         S_PAR: begin
            svalid_d = 1'b1;
            sout_d   = par_d;
         end
`endif
         default: begin
            sout_d   = 1'b0;
            svalid_d = 1'b0;
         end
      endcase
   end

   assign SOUT   = sout_q;
   assign SVALID = svalid_q;
   assign BUSY   = busy_q;
   assign DONE   = done_q;

endmodule
